// File: rtl/eth_10g_mac_tx_st_ready_latency_adapter_pkg.sv
// Shared defaults and framing state encoding for the
// 10G MAC TX ready-latency adapter.
package eth_10g_mac_tx_st_ready_latency_adapter_pkg;

    localparam int DEF_DATA_W  = 64;
    localparam int DEF_EMPTY_W = 3;
    localparam int DEF_DEPTH   = 4;

    typedef enum logic {
        IDLE,
        IN_PKT
    } state_t;

endpackage

// File: rtl/eth_10g_st_sync_fifo.sv
// Single-clock FIFO for Avalon-ST beats with an occupancy count.
// Caller must not push when full or pop when empty.
module eth_10g_st_sync_fifo
    import eth_10g_mac_tx_st_ready_latency_adapter_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    assign rdata = mem[rptr];

    // Pointer and occupancy tracking; push and pop together keep count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/eth_10g_mac_tx_st_ready_latency_adapter.sv
// Converts a ready-latency-0 stream into a ready-latency-1 stream,
// enforcing SOP/EOP framing and counting discarded stray beats.
module eth_10g_mac_tx_st_ready_latency_adapter
    import eth_10g_mac_tx_st_ready_latency_adapter_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int EMPTY_W = DEF_EMPTY_W,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_error,
    input  logic               in_startofpacket,
    input  logic               in_endofpacket,
    input  logic [EMPTY_W-1:0] in_empty,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_error,
    output logic               out_startofpacket,
    output logic               out_endofpacket,
    output logic [EMPTY_W-1:0] out_empty,
    output logic [15:0]        drop_count
);

    localparam int PW = DATA_W + EMPTY_W + 3;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    state_t state_q;
    state_t state_d;

    logic               acc;
    logic               wr;
    logic               drop;
    logic               w_err;
    logic [EMPTY_W-1:0] w_empty;
    logic               pop;
    logic [PW-1:0]      wdata;
    logic [PW-1:0]      rdata;
    logic [CW-1:0]      count;

    assign in_ready = reset_n && (count < FULL);
    assign acc      = in_valid && in_ready;
    assign pop      = out_ready && (count != '0);
    assign wdata    = {in_data, w_err, in_startofpacket,
                       in_endofpacket, w_empty};

    eth_10g_st_sync_fifo #(
        .W     (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (wr),
        .pop     (pop),
        .wdata   (wdata),
        .rdata   (rdata),
        .count   (count)
    );

    // Framing state register.
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Framing decisions: drop strays, flag truncated frames, clean empty.
    always_comb begin
        state_d = state_q;
        wr      = 1'b0;
        drop    = 1'b0;
        w_err   = in_error;
        w_empty = in_endofpacket ? in_empty : '0;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    if (!in_startofpacket) begin
                        drop = 1'b1;
                    end else begin
                        wr = 1'b1;
                        if (!in_endofpacket) state_d = IN_PKT;
                    end
                end
            end
            IN_PKT: begin
                if (acc) begin
                    wr = 1'b1;
                    if (in_startofpacket) w_err = 1'b1;
                    if (in_endofpacket)   state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Saturating count of discarded beats.
    always_ff @(posedge clk) begin
        if (!reset_n)
            drop_count <= '0;
        else if (drop && drop_count != 16'hFFFF)
            drop_count <= drop_count + 16'd1;
    end

    // Output register: a beat is launched only for an out_ready seen
    // in the previous cycle, which gives the downstream latency of 1.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_error         <= 1'b0;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
            out_empty         <= '0;
        end else if (pop) begin
            out_valid         <= 1'b1;
            {out_data, out_error, out_startofpacket,
             out_endofpacket, out_empty} <= rdata;
        end else begin
            out_valid         <= 1'b0;
            out_error         <= 1'b0;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_eth_10g_mac_tx_st_ready_latency_adapter.sv
// Scoreboard bench for the ready-latency adapter: directed frames,
// back-pressure, stray beats, reset flush and counter saturation.
module tb_eth_10g_mac_tx_st_ready_latency_adapter;

    typedef struct packed {
        logic [63:0] data;
        logic        err;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_error;
    logic        in_startofpacket;
    logic        in_endofpacket;
    logic [2:0]  in_empty;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_error;
    logic        out_startofpacket;
    logic        out_endofpacket;
    logic [2:0]  out_empty;
    logic [15:0] drop_count;

    eth_10g_mac_tx_st_ready_latency_adapter dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .in_error          (in_error),
        .in_startofpacket  (in_startofpacket),
        .in_endofpacket    (in_endofpacket),
        .in_empty          (in_empty),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_error         (out_error),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .out_empty         (out_empty),
        .drop_count        (drop_count)
    );

    always #5 clk = ~clk;

    int    cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int    total = 0;
    int    bad   = 0;
    int    n_acc = 0;
    int    acc_cyc;
    int    lat_cyc = -1;
    bit    lat_arm = 0;
    bit    prev_rdy = 0;
    beat_t q[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk(input logic [63:0] d, input logic e,
                                 input logic s, input logic p,
                                 input logic [2:0] m);
        beat_t b;
        b.data = d; b.err = e; b.sop = s; b.eop = p; b.empty = m;
        return b;
    endfunction

    task automatic monitor();
        beat_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_rdy = 1'b0;
            end else begin
                if (out_valid) begin
                    chk("solicited", {63'd0, prev_rdy}, 64'd1);
                    if (lat_arm) begin
                        lat_cyc = cyc;
                        lat_arm = 0;
                    end
                    if (q.size() == 0) begin
                        chk("unexpected_beat", out_data, 64'hDEAD);
                        total++;
                        bad++;
                        $display("FAIL unexpected: beat data %0h",
                                 out_data);
                    end else begin
                        e = q.pop_front();
                        chk("beat_data", out_data, e.data);
                        chk("beat_ctl",
                            {58'd0, out_error, out_startofpacket,
                             out_endofpacket, out_empty},
                            {58'd0, e.err, e.sop, e.eop, e.empty});
                    end
                end else begin
                    chk("idle_ctl",
                        {61'd0, out_error, out_startofpacket,
                         out_endofpacket}, 64'd0);
                end
                prev_rdy = out_ready;
            end
        end
    endtask

    task automatic send(input beat_t b, input bit keep, input beat_t e);
        int k;
        in_valid         = 1'b1;
        in_data          = b.data;
        in_error         = b.err;
        in_startofpacket = b.sop;
        in_endofpacket   = b.eop;
        in_empty         = b.empty;
        k = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            k++;
            if (k > 200) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: in_ready 0 for %0d", k);
                break;
            end
        end
        if (in_ready) begin
            acc_cyc = cyc;
            n_acc++;
            if (keep) q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pass(input beat_t b);
        send(b, 1'b1, b);
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int    t0;
        int    base;
        beat_t z;
        z = mk(64'd0, 0, 0, 0, 3'd0);
        reset_n = 0; out_ready = 1; in_valid = 0;
        in_data = '0; in_error = 0; in_startofpacket = 0;
        in_endofpacket = 0; in_empty = '0;
        fork monitor(); join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_drop", {48'd0, drop_count}, 64'd0);
        chk("rst_data", out_data, 64'd0);
        @(posedge clk); #1;
        reset_n = 1;
        @(negedge clk);
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        drain(1);

        // 3-beat frame, continuous out_ready
        lat_arm = 1;
        pass(mk(64'h1111_2222_3333_4444, 0, 1, 0, 3'd0));
        t0 = acc_cyc;
        pass(mk(64'h5555_6666_7777_8888, 0, 0, 0, 3'd0));
        pass(mk(64'h9999_AAAA_BBBB_CCCC, 0, 0, 1, 3'd5));
        drain(8);
        chk("latency", 64'(lat_cyc - t0), 64'd2);
        chk("t1_drop", {48'd0, drop_count}, 64'd0);
        chk("t1_drained", 64'(q.size()), 64'd0);

        // 6-beat frame with 10 cycles of back-pressure
        out_ready = 0;
        base = n_acc;
        fork
            begin
                pass(mk(64'hA0, 0, 1, 0, 3'd0));
                pass(mk(64'hA1, 0, 0, 0, 3'd0));
                pass(mk(64'hA2, 0, 0, 0, 3'd0));
                pass(mk(64'hA3, 0, 0, 0, 3'd0));
                pass(mk(64'hA4, 0, 0, 0, 3'd0));
                pass(mk(64'hA5, 0, 0, 1, 3'd2));
            end
            begin
                repeat (10) @(negedge clk);
                chk("bp_accepts", 64'(n_acc - base), 64'd4);
                chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
                chk("bp_no_valid", {63'd0, out_valid}, 64'd0);
                @(posedge clk); #1;
                out_ready = 1;
            end
        join
        drain(10);
        chk("t2_drained", 64'(q.size()), 64'd0);

        // stray beat in IDLE followed by a valid frame
        send(mk(64'hBAD0, 0, 0, 0, 3'd0), 1'b0, z);
        pass(mk(64'hC0, 0, 1, 0, 3'd0));
        pass(mk(64'hC1, 0, 0, 1, 3'd1));
        drain(8);
        chk("t3_drop", {48'd0, drop_count}, 64'd1);
        chk("t3_drained", 64'(q.size()), 64'd0);

        // SOP inside a frame, and empty cleared on non-EOP
        pass(mk(64'hD0, 0, 1, 0, 3'd0));
        send(mk(64'hD1, 0, 0, 0, 3'd7), 1'b1,
             mk(64'hD1, 0, 0, 0, 3'd0));
        send(mk(64'hD2, 0, 1, 0, 3'd0), 1'b1,
             mk(64'hD2, 1, 1, 0, 3'd0));
        pass(mk(64'hD3, 0, 0, 1, 3'd4));
        drain(8);
        chk("t4_drained", 64'(q.size()), 64'd0);

        // reset with three beats buffered mid-frame
        out_ready = 0;
        pass(mk(64'hE0, 0, 1, 0, 3'd0));
        pass(mk(64'hE1, 0, 0, 0, 3'd0));
        pass(mk(64'hE2, 0, 0, 0, 3'd0));
        reset_n = 0;
        q.delete();
        drain(2);
        reset_n = 1;
        @(negedge clk);
        chk("t5_out_valid", {63'd0, out_valid}, 64'd0);
        chk("t5_in_ready", {63'd0, in_ready}, 64'd1);
        chk("t5_drop", {48'd0, drop_count}, 64'd0);
        @(posedge clk); #1;
        out_ready = 1;
        drain(12);

        // stray-beat flood to saturate the drop counter
        in_valid = 1; in_startofpacket = 0; in_endofpacket = 0;
        in_data = 64'hF00D; in_empty = '0; in_error = 0;
        repeat (65535) @(posedge clk);
        #1;
        chk("sat_edge", {48'd0, drop_count}, 64'hFFFF);
        repeat (4465) @(posedge clk);
        #1;
        in_valid = 0;
        drain(2);
        chk("sat_hold", {48'd0, drop_count}, 64'hFFFF);
        chk("final_drained", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eth_10g_mac_tx_st_ready_latency_adapter.md
ETH_10G_MAC_TX_ST_READY_LATENCY_ADAPTER -- requirements
Module: eth_10g_mac_tx_st_ready_latency_adapter

Interface
REQ-001 SHALL have parameter DATA_W, default 64, data bus width.
REQ-002 SHALL have parameter EMPTY_W, default 3, empty-symbol count width.
REQ-003 SHALL have parameter DEPTH, default 4, FIFO entries; power of 2, minimum 2.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 in_valid, in_ready  input, output  1 each  upstream handshake, ready latency 0.
REQ-007 in_data, in_error, in_startofpacket, in_endofpacket, in_empty  input  DATA_W/1/1/1/EMPTY_W  upstream payload.
REQ-008 out_valid, out_ready  output, input  1 each  downstream handshake, ready latency 1.
REQ-009 out_data, out_error, out_startofpacket, out_endofpacket, out_empty  output  DATA_W/1/1/1/EMPTY_W  registered downstream payload.
REQ-010 drop_count  output  16  saturating count of beats discarded by the framing checker.

Function
REQ-011 Upstream beat accepted SHALL mean in_valid=1 and in_ready=1 in the same cycle.
REQ-012 in_ready SHALL be 1 exactly when FIFO occupancy < DEPTH, registered-free (combinational from occupancy).
REQ-013 out_valid SHALL assert in cycle n+1 only if out_ready=1 in cycle n and FIFO non-empty at cycle n+1 start; each out_valid beat pops one entry.
REQ-014 out_valid SHALL never assert in a cycle following out_ready=0; downstream never sees an unsolicited beat.
REQ-015 Outputs SHALL be registered; minimum latency accepted-beat to out_valid = 2 cycles with out_ready held 1.
REQ-016 Simultaneous push and pop SHALL leave occupancy unchanged; push at full is impossible (in_ready=0).
REQ-017 Framing FSM states: IDLE, IN_PKT; reset state IDLE.
REQ-018 IDLE: accepted beat with SOP=0 SHALL be dropped (not written) and drop_count incremented.
REQ-019 IDLE: accepted SOP beat written; EOP=0 -> IN_PKT, EOP=1 -> stays IDLE (single-beat frame).
REQ-020 IN_PKT: accepted beat written; EOP=1 -> IDLE.
REQ-021 IN_PKT: accepted beat with SOP=1 SHALL be written with error forced 1 (truncated previous frame flagged), state remains IN_PKT unless EOP=1.
REQ-022 Written empty SHALL be forced 0 on beats with EOP=0.
REQ-023 drop_count SHALL saturate at 0xFFFF, never wrap.
REQ-024 When out_valid=0, out_data/out_empty hold last value; out_startofpacket/out_endofpacket/out_error SHALL be 0.

Reset
REQ-025 While reset_n=0 at a clock edge: FIFO empty, FSM IDLE, drop_count 0, out_valid 0, out_* payload 0, registered out_ready 0.
REQ-026 in_ready SHALL be 0 during reset and 1 in the first cycle after deassertion.
REQ-027 Reset mid-frame SHALL discard buffered beats; no partial frame emitted after reset.

Structure
REQ-028 Shared package SHALL hold default DATA_W, EMPTY_W, DEPTH and the FSM state enum.
REQ-029 FIFO SHALL be a sub-module eth_10g_st_sync_fifo (payload width, DEPTH, push/pop, count).
REQ-030 Framing FSM, ready-latency registration and drop counter live in the top module.

Verification
REQ-031 3-beat frame (SOP, mid, EOP empty=5), out_ready=1 constant -> identical beats out, first out_valid 2 cycles after first accept, drop_count 0.
REQ-032 out_ready=0 for 10 cycles during 6-beat frame -> in_ready drops after 4 accepts, no out_valid in any cycle after out_ready=0, all 6 beats delivered in order.
REQ-033 Beat with SOP=0 in IDLE, then valid frame -> stray beat absent at output, drop_count=1.
REQ-034 SOP-beat arrives in IN_PKT -> output beat has sop=1, error=1; non-EOP beat sent with in_empty=7 -> out_empty=0.
REQ-035 Reset asserted with 3 beats buffered -> after release out_valid=0, in_ready=1, drop_count=0, no stale beats emitted.
REQ-036 70000 stray beats -> drop_count=0xFFFF.
